// File: rtl/vga_line_fetch.sv
// Scanline fetch controller: ping-pong line buffers filled by framebuffer bursts, scan-doubled readout.
// Optional saturating underrun counter output enabled by VGA_LINE_FETCH_UNDERRUN_CNT_EN.
module vga_line_fetch #(
    parameter int BPP    = 4,
    parameter int HPIX   = 320,
    parameter int VLINES = 240,
    parameter int ADDR_W = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame,
    input  logic                newline,
    input  logic                advance,
    input  logic [7:0]          line,
    output logic [3*BPP-1:0]    pixel,
    input  logic [ADDR_W-1:0]   fb_base,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [3*BPP-1:0]    mem_rdata,
    output logic                underrun
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    ,
    output logic [7:0]          underrun_cnt
`endif
);
    localparam int         PW      = 3*BPP;
    localparam logic [7:0] INVALID = 8'hFF;
    localparam logic [9:0] XMAX    = 10'(2*HPIX-1);
    localparam logic [8:0] WLAST   = 9'(HPIX-1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [PW-1:0]     buf0 [HPIX];
    logic [PW-1:0]     buf1 [HPIX];
    logic [7:0]        last_fetched;
    logic [7:0]        fetch_line;
    logic [8:0]        wcnt;
    logic              disp_sel;
    logic [9:0]        xcnt;

    logic [7:0]        next_line;
    logic              nl_trig;
    logic              ur_event;
    logic              start_go;
    logic [7:0]        start_line;
    logic [ADDR_W-1:0] start_addr;
    logic              buf_we;

    assign next_line = line + 8'd1;
    assign nl_trig   = newline && (line < 8'(VLINES-1)) && (last_fetched != next_line);
    assign ur_event  = newline && (line < 8'(VLINES)) && (last_fetched != line);
    assign buf_we    = (state == FETCH) && mem_ack && !frame;

    // Every burst start funnels through here: a fresh trigger in IDLE, or a frame restart to line 0.
    always_comb begin
        start_go   = 1'b0;
        start_line = 8'd0;
        case (state)
            IDLE: begin
                start_go   = frame || nl_trig;
                start_line = frame ? 8'd0 : next_line;
            end
            FETCH:   start_go = frame && mem_ack;
            DRAIN:   start_go = mem_ack;
            default: start_go = 1'b0;
        endcase
        start_addr = fb_base + ADDR_W'(start_line) * ADDR_W'(HPIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            last_fetched <= INVALID;
            fetch_line   <= 8'd0;
            wcnt         <= 9'd0;
            underrun     <= 1'b0;
        end else begin
            if (ur_event)
                underrun <= 1'b1;
            if (start_go) begin
                state      <= FETCH;
                mem_req    <= 1'b1;
                fetch_line <= start_line;
                mem_addr   <= start_addr;
                wcnt       <= 9'd0;
                if (last_fetched == start_line)
                    last_fetched <= INVALID;
            end else begin
                case (state)
                    FETCH: begin
                        if (frame) begin
                            state <= DRAIN;
                        end else if (mem_ack) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            wcnt     <= wcnt + 9'd1;
                            if (wcnt == WLAST) begin
                                last_fetched <= fetch_line;
                                mem_req      <= 1'b0;
                                state        <= IDLE;
                            end
                        end
                    end
                    DRAIN:   mem_req <= 1'b1;
                    IDLE:    mem_req <= 1'b0;
                    default: state   <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            if (fetch_line[0])
                buf1[wcnt] <= mem_rdata;
            else
                buf0[wcnt] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_sel <= 1'b0;
            xcnt     <= 10'd0;
        end else if (newline) begin
            disp_sel <= line[0];
            xcnt     <= 10'd0;
        end else if (advance && xcnt != XMAX) begin
            xcnt <= xcnt + 10'd1;
        end
    end

    assign pixel = disp_sel ? buf1[xcnt[9:1]] : buf0[xcnt[9:1]];

`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            underrun_cnt <= 8'd0;
        else if (ur_event && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: framebuffer model returns addr[11:0] as data, so every
// displayed pixel is predicted from source line and horizontal position alone.
module tb_vga_line_fetch;
    localparam int BPP = 4, HPIX = 320, VLINES = 240, ADDR_W = 17, PW = 12;
    localparam int BASE = 'h1000;

    logic              clk = 1'b0;
    logic              reset, frame, newline, advance;
    logic [7:0]        line;
    logic [PW-1:0]     pixel;
    logic [ADDR_W-1:0] fb_base;
    logic              mem_req, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [PW-1:0]     mem_rdata;
    logic              underrun;
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
    logic [7:0]        underrun_cnt;
`endif

    int n_checks = 0, n_fail = 0;
    int ack_mode = 0;   // 0 tied high, 1 every 3rd cycle, 2 stalled
    int tick = 0;
    bit chk_pix = 0;
    logic [ADDR_W-1:0] ack_q[$];
    int req_cycles = 0;

    vga_line_fetch #(.BPP(BPP), .HPIX(HPIX), .VLINES(VLINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .frame(frame), .newline(newline), .advance(advance),
        .line(line), .pixel(pixel), .fb_base(fb_base), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .underrun(underrun)
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr[PW-1:0];
    assign mem_ack   = (ack_mode == 0) || (ack_mode == 1 && tick == 0);
    always @(posedge clk) tick <= (tick == 2) ? 0 : tick + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shown pixel = framebuffer word of (line, x/2); memory handshake rules.
    int  mdl_line = 0, mdl_x = 0;
    bit  have_prev = 0;
    logic prev_req, prev_ack;
    logic [ADDR_W-1:0] prev_addr;
    always @(negedge clk) begin
        if (reset) begin
            have_prev = 0;
        end else begin
            if (have_prev && prev_req && !prev_ack) begin
                check("req_held", mem_req, 1);
                check("addr_held", mem_addr, prev_addr);
            end
            if (mem_req && mem_ack) ack_q.push_back(mem_addr);
            if (mem_req) req_cycles++;
            if (newline) begin
                mdl_line = line;
                mdl_x    = 0;
            end else if (advance) begin
                if (chk_pix)
                    check("pixel", pixel, (BASE + mdl_line*HPIX + mdl_x/2) & 'hFFF);
                if (mdl_x < 2*HPIX-1) mdl_x++;
            end
            have_prev = 1;
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_nl(input int l);
        line = 8'(l); newline = 1; cyc(1); newline = 0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (mem_req && k < max) begin cyc(1); k++; end
        check("burst_done", mem_req, 0);
    endtask

    task automatic check_burst(input int start);
        int errs = 0;
        for (int i = 0; i < ack_q.size(); i++)
            if (ack_q[i] !== ADDR_W'(start + i)) errs++;
        check("burst_len", ack_q.size(), HPIX);
        check("burst_order", errs, 0);
    endtask

    task automatic show_line();
        chk_pix = 1;
        for (int i = 0; i < 2*HPIX; i++) begin
            advance = 1;
            cyc(1);
        end
        advance = 0;
        chk_pix = 0;
    endtask

    initial begin
        reset = 1; frame = 0; newline = 0; advance = 0; line = 0; fb_base = ADDR_W'(BASE);
        cyc(3);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_underrun", underrun, 0);
        reset = 0;
        cyc(1);

        // line 0 burst with ack tied high
        ack_q.delete(); req_cycles = 0;
        frame = 1; cyc(1); frame = 0;
        check("first_addr", mem_addr, 'h1000);
        check("first_req", mem_req, 1);
        cyc(1);
        check("second_addr", mem_addr, 'h1001);
        wait_idle(400);
        check_burst('h1000);
        check("req_cycles", req_cycles, 320);

        // display line 0 while line 1 fetches
        ack_q.delete();
        pulse_nl(0);
        check("line1_addr", mem_addr, 'h1140);
        advance = 1;
        check("pix_first", pixel, 0);
        cyc(1);
        check("pix_second", pixel, 0);
        cyc(1);
        check("pix_third", pixel, 1);
        advance = 0;
        pulse_nl(0);
        chk_pix = 1;
        for (int i = 0; i < 2*HPIX; i++) begin
            advance = 1;
            if (i == 2*HPIX-1) check("pix_last", pixel, 'h13F);
            cyc(1);
        end
        advance = 0; chk_pix = 0;
        wait_idle(400);
        check_burst('h1140);

        // ack every third cycle
        ack_mode = 1; ack_q.delete();
        pulse_nl(1);
        check("line2_addr", mem_addr, 'h1280);
        show_line();
        wait_idle(1200);
        check_burst('h1280);
        check("no_underrun", underrun, 0);
        ack_mode = 0;

        // underrun while line 5 fetch stalls
        pulse_nl(2); wait_idle(400);
        pulse_nl(3); wait_idle(400);
        ack_mode = 2;
        pulse_nl(4);
        check("line5_addr", mem_addr, 'h1640);
        cyc(2000);
        check("stall_req", mem_req, 1);
        pulse_nl(5);
        check("underrun_set", underrun, 1);
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        check("underrun_cnt1", underrun_cnt, 1);
`endif
        ack_q.delete(); ack_mode = 0;
        wait_idle(400);
        check_burst('h1640);
        pulse_nl(5);
        check("line6_req", mem_req, 1);
        check("line6_addr", mem_addr, 'h1780);
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        check("underrun_cnt_hold", underrun_cnt, 1);
`endif
        wait_idle(400);

        // frame restart in the middle of line 7
        ack_q.delete();
        pulse_nl(6);
        check("line7_addr", mem_addr, 'h18C0);
        for (int k = 0; k < 400 && ack_q.size() < 100; k++) cyc(1);
        check("reach_wcnt100", ack_q.size(), 100);
        ack_mode = 2; frame = 1; cyc(1); frame = 0;
        for (int k = 0; k < 3; k++) begin
            check("drain_req", mem_req, 1);
            cyc(1);
        end
        ack_mode = 0;
        cyc(1);
        ack_q.delete();
        check("restart_addr", mem_addr, 'h1000);
        check("restart_req", mem_req, 1);
        wait_idle(400);
        check_burst('h1000);

        // reset mid-burst
        pulse_nl(0);
        cyc(5);
        check("pre_reset_req", mem_req, 1);
        reset = 1; cyc(1);
        check("reset_req", mem_req, 0);
        check("reset_underrun", underrun, 0);
        reset = 0;
        cyc(1);

        // blanking and last-line boundaries
        pulse_nl(250);
        cyc(3);
        check("blank_nofetch", mem_req, 0);
        check("blank_nounderrun", underrun, 0);
        pulse_nl(239);
        cyc(3);
        check("l239_nofetch", mem_req, 0);
        check("l239_underrun", underrun, 1);
`ifdef VGA_LINE_FETCH_UNDERRUN_CNT_EN
        check("l239_cnt", underrun_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Scanline fetch controller that sits between the vga timing generator and a shared framebuffer read port.
- Owns two ping-pong line buffers of HPIX pixels each, for a 320x240 source image scan-doubled to 640x480.
- On vga `frame`/`newline` events it schedules burst reads of the next source line into the idle buffer.
- On `advance` it supplies the `pixel` word combinationally, each source pixel shown twice horizontally.

Parameters:
- BPP, 4, bits per colour channel; pixel word is 3*BPP bits.
- HPIX, 320, source pixels per line.
- VLINES, 240, source lines per frame.
- ADDR_W, 17, framebuffer word-address width.

Ports:
- clk  in  1  system clock (pixel clock).
- reset  in  1  synchronous, active-high reset.
- frame  in  1  one-cycle start-of-frame pulse from vga.
- newline  in  1  one-cycle start-of-line pulse from vga.
- advance  in  1  high on every active pixel cycle.
- line  in  8  source line about to be displayed; values >= VLINES mean blanking.
- pixel  out  3*BPP  pixel for the current advance cycle.
- fb_base  in  ADDR_W  framebuffer base word address; sampled at fetch start.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  read word address.
- mem_ack  in  1  read accepted; mem_rdata valid this cycle.
- mem_rdata  in  3*BPP  read data.
- underrun  out  1  sticky: a displayed line was not fully fetched.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=0, underrun=0, state IDLE.
  - last_fetched=all-ones (invalid), disp_sel=0, xcnt=0.
  - Buffer contents undefined; pixel is don't-care until first fetch.
- Reset mid-burst drops mem_req the same cycle (memory side shares reset).
- Buffer mapping: source line S lives in buffer S[0].
- Readout:
  - On newline: disp_sel<=line[0]; xcnt<=0.
  - On advance: xcnt<=xcnt+1 (10 bits).
  - pixel = buf[disp_sel][xcnt[9:1]], combinational, zero latency.
  - xcnt saturates at 2*HPIX-1.
- Fetch triggers, evaluated in IDLE:
  - frame pulse -> fetch S=0.
  - newline with line<VLINES-1 and last_fetched!=line+1 -> fetch S=line+1.
  - Both in the same cycle -> frame wins.
- A trigger seen while not IDLE is dropped. The next newline re-evaluates it naturally because last_fetched is unchanged.
- FSM states:
  - IDLE -> FETCH on a trigger. Latch fetch_line=S, mem_addr=fb_base+S*HPIX (computed with an adder chain or multiplier, truncated to ADDR_W), wcnt=0, and clear last_fetched to invalid if it equals S.
  - FETCH: mem_req=1, mem_addr held stable until mem_ack.
    - On ack: buf[S[0]][wcnt]<=mem_rdata; mem_addr+=1; wcnt+=1.
    - On ack with wcnt==HPIX-1: last_fetched<=S; mem_req falls the next cycle; go to IDLE.
    - mem_req may stay high back-to-back; one word per ack cycle.
  - FETCH + frame pulse -> DRAIN.
  - DRAIN: mem_req held at 1 until ack (a request is never withdrawn unacked). The acked word is discarded. Then go to FETCH for line 0 directly (restarted burst).
- Underrun: set on newline with line<VLINES when last_fetched!=line. This includes a fetch still in progress for that line. Cleared only by reset.
- Writes into the displayed buffer cannot occur by construction. The fetched line S+1 always has the opposite parity to the displayed line S.

Optional Feature:
- Macro: VGA_LINE_FETCH_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [7:0]. It increments on each underrun event, saturates at 255, and resets to 0.
- Undefined: port absent; only the sticky underrun flag exists.

Test Plan:
- Reset, then frame pulse, fb_base=0x1000, mem_ack tied 1 -> mem_addr 0x1000..0x113F over 320 consecutive cycles; mem_req drops after the 320th ack; last_fetched=0.
- After line 0 is loaded with data=index, newline with line=0, then 640 advance cycles -> pixel sequence 0,0,1,1,…,319,319; a fetch of line 1 starts (addr 0x1140) in the same window.
- mem_ack asserted every 3rd cycle -> mem_addr changes only after ack cycles; 320 words land in order; no dropped or duplicated word.
- Stall mem_ack for 2000 cycles during the line-5 fetch, then newline with line=5 -> underrun=1 (count=1 with the macro); line-5 fetch completes; the next newline triggers line 6.
- frame pulse at wcnt=100 of a line-7 fetch with ack delayed 4 cycles -> mem_req stays high until ack, then mem_addr=fb_base+0 and a full line-0 burst follows.
- newline with line=239 and line=250 -> no fetch issued and no underrun for line=250; synchronous reset mid-burst -> mem_req=0 next edge, underrun=0.
